// File: rtl/instr_encoder_loader.sv
// Encodes symbolic RV64 instruction requests and writes them one word at a time
// into instruction memory through a single write port.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [12:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [6:0]        count,
  output logic              full,
  output logic              err
);

  typedef enum logic [0:0] {StIdle, StWrite} state_e;

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
  localparam logic [6:0]        DepthCnt = 7'(DEPTH);

  localparam logic [6:0] OpImm  = 7'b0010011;
  localparam logic [6:0] OpReg  = 7'b0110011;
  localparam logic [6:0] OpLoad = 7'b0000011;
  localparam logic [6:0] OpStr  = 7'b0100011;
  localparam logic [6:0] OpBr   = 7'b1100011;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [6:0]        count_q, count_d;
  logic              full_q, full_d;
  logic              err_q, err_d;
  logic              op_legal;
  logic [31:0]       enc_word;

  always_comb begin
    enc_word = 32'h0;
    op_legal = 1'b1;
    unique case (in_op)
      4'd0: enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OpImm};
      4'd1: enc_word = {6'b000000, in_imm[5:0], in_rs1, 3'b001, in_rd, OpImm};
      4'd2: enc_word = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OpReg};
      4'd3: enc_word = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, OpReg};
      4'd4: enc_word = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, OpReg};
      4'd5: enc_word = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, OpReg};
      4'd6: enc_word = {in_imm[11:0], in_rs1, 3'b011, in_rd, OpLoad};
      4'd7: enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b011, in_imm[4:0], OpStr};
      4'd8: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                        in_imm[4:1], in_imm[11], OpBr};
      4'd9: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b100,
                        in_imm[4:1], in_imm[11], OpBr};
      default: op_legal = 1'b0;
    endcase
  end

  // Clear and reset both block acceptance in the cycle they are asserted.
  assign in_ready  = (state_q == StIdle) && !full_q && !clear && !reset;
  assign mem_we    = (state_q == StWrite) && !clear;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign full      = full_q;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    full_d  = full_q;
    err_d   = err_q;
    if (clear) begin
      state_d = StIdle;
      addr_d  = BaseAddr;
      count_d = 7'd0;
      full_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            if (op_legal) begin
              wdata_d = enc_word;
              state_d = StWrite;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        StWrite: begin
          addr_d  = addr_q + ADDR_W'(4);
          count_d = count_q + 7'd1;
          full_d  = (count_q + 7'd1) == DepthCnt;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= BaseAddr;
      wdata_q <= 32'h0;
      count_q <= 7'd0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: encodings, stream handshake, illegal op,
// fill to depth, clear and asynchronous reset.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = 4'd0;
  logic [4:0]  in_rd = 5'd0;
  logic [4:0]  in_rs1 = 5'd0;
  logic [4:0]  in_rs2 = 5'd0;
  logic [12:0] in_imm = 13'd0;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [6:0]  count;
  logic        full;
  logic        err;

  int total = 0;
  int bad = 0;

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(64), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count),
    .full(full), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // Presents one request from an IDLE cycle and checks the resulting write cycle.
  // in_valid is left high so consecutive calls form a back-to-back stream.
  task automatic put(input string tag, input logic [3:0] op, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm,
                     input logic [31:0] exp_word, input logic [7:0] exp_addr);
    @(negedge clk);
    in_valid = 1'b1;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    #1 chk({tag, "_ready1"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    chk({tag, "_we"}, 32'(mem_we), 32'd1);
    chk({tag, "_ready0"}, 32'(in_ready), 32'd0);
    chk({tag, "_word"}, mem_wdata, exp_word);
    chk({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    #2 check_reset_values("rst");
    @(negedge clk);
    reset = 1'b0;

    // Single addi
    put("addi", 4'd0, 5'd5, 5'd0, 5'd0, 13'd10, 32'h00A00293, 8'h00);
    in_valid = 1'b0;
    chk("addi_cnt_during", 32'(count), 32'd0);
    @(negedge clk);
    chk("addi_we_low", 32'(mem_we), 32'd0);
    chk("addi_cnt", 32'(count), 32'd1);
    chk("addi_addr_next", 32'(mem_addr), 32'h04);
    do_clear();
    chk("clr1_cnt", 32'(count), 32'd0);
    chk("clr1_addr", 32'(mem_addr), 32'd0);

    // Back-to-back stream, then branches and shift
    put("add", 4'd2, 5'd3, 5'd1, 5'd2, 13'd0, 32'h002081B3, 8'h00);
    put("sub", 4'd3, 5'd3, 5'd1, 5'd2, 13'd0, 32'h402081B3, 8'h04);
    put("ld", 4'd6, 5'd6, 5'd2, 5'd0, 13'd8, 32'h00813303, 8'h08);
    put("sd", 4'd7, 5'd0, 5'd2, 5'd6, 13'd16, 32'h00613823, 8'h0C);
    put("beq", 4'd8, 5'd0, 5'd1, 5'd2, 13'd8, 32'h00208463, 8'h10);
    put("blt", 4'd9, 5'd0, 5'd1, 5'd2, 13'h1FFC, 32'hFE20CEE3, 8'h14);
    put("slli", 4'd1, 5'd7, 5'd7, 5'd0, 13'd3, 32'h00339393, 8'h18);
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_cnt", 32'(count), 32'd7);

    // Illegal op
    in_valid = 1'b1; in_op = 4'd12;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk("ill_cnt", 32'(count), 32'd7);
    chk("ill_we2", 32'(mem_we), 32'd0);
    put("post_ill", 4'd0, 5'd5, 5'd0, 5'd0, 13'd10, 32'h00A00293, 8'h1C);
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_ill_cnt", 32'(count), 32'd8);
    chk("post_ill_err", 32'(err), 32'd1);
    do_clear();
    chk("clr2_err", 32'(err), 32'd0);

    // Fill to depth
    for (int i = 0; i < 64; i++) begin
      put("fill", 4'd0, 5'd5, 5'd0, 5'd0, 13'd10, 32'h00A00293, 8'(i * 4));
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_addr", 32'(mem_addr), 32'h00);
    chk("full_cnt", 32'(count), 32'd64);
    in_valid = 1'b1; in_op = 4'd0; in_rd = 5'd1; in_rs1 = 5'd0; in_imm = 13'd10;
    repeat (2) @(negedge clk);
    chk("pend_we", 32'(mem_we), 32'd0);
    chk("pend_cnt", 32'(count), 32'd64);
    chk("pend_ready", 32'(in_ready), 32'd0);
    clear = 1'b1;
    #1 chk("clr_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("clr3_full", 32'(full), 32'd0);
    chk("clr3_cnt", 32'(count), 32'd0);
    chk("clr3_addr", 32'(mem_addr), 32'd0);
    chk("clr3_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pend_acc_we", 32'(mem_we), 32'd1);
    chk("pend_acc_word", mem_wdata, 32'h00A00093);
    @(negedge clk);
    chk("pend_acc_cnt", 32'(count), 32'd1);

    // Clear during WRITE
    put("cw", 4'd2, 5'd3, 5'd1, 5'd2, 13'd0, 32'h002081B3, 8'h04);
    in_valid = 1'b0;
    clear = 1'b1;
    #1 chk("cw_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    clear = 1'b0;
    chk("cw_cnt", 32'(count), 32'd0);
    chk("cw_we2", 32'(mem_we), 32'd0);
    chk("cw_addr", 32'(mem_addr), 32'd0);

    // Asynchronous reset during WRITE
    put("rw", 4'd3, 5'd3, 5'd1, 5'd2, 13'd0, 32'h402081B3, 8'h00);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_values("rw_rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rw_cnt_after", 32'(count), 32'd0);
    chk("rw_ready_after", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the control/decode path. Accepts symbolic instruction requests (op select, registers, immediate) over a valid/ready handshake.
- Encodes each request into a 32-bit RV64 instruction word for the subset the core executes.
- Writes the words sequentially into instruction memory through a single write port.
- Used by the testbench and boot path to load programs before the pipeline is released from reset.

Parameters:
- ADDR_W, 8, width of mem_addr (byte address).
- DEPTH, 64, maximum number of words written before full.
- BASE_ADDR, 0, byte address of the first word written.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous restart: pointer, count, err and full return to reset values.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request this cycle.
- in_op  input  4  0 addi, 1 slli, 2 add, 3 sub, 4 and, 5 or, 6 ld, 7 sd, 8 beq, 9 blt; 10–15 illegal.
- in_rd  input  5  destination register.
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2.
- in_imm  input  13  signed immediate. I/S types use [11:0]; slli shamt uses [5:0]; branch offset uses [12:0] with bit0 ignored.
- mem_we  output  1  instruction-memory write strobe.
- mem_addr  output  ADDR_W  byte address of the write.
- mem_wdata  output  32  encoded instruction word.
- count  output  7  number of words written, 0..DEPTH.
- full  output  1  count == DEPTH.
- err  output  1  sticky flag: an illegal in_op was accepted.

Behaviour:
- Reset (async, immediate): state IDLE; mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, full=0, err=0, in_ready=0 while reset is high.
- States and transitions:
  - IDLE: in_ready = !full.
    - in_valid && in_ready, legal op: encode and register the word into mem_wdata, go to WRITE.
    - Illegal op: set err, stay in IDLE, write nothing.
  - WRITE: in_ready=0; mem_we=1 for exactly this cycle at mem_addr.
    - Next cycle: mem_addr += 4, count += 1, full = (count+1 == DEPTH), go to IDLE.
  - Result: latency is accept → mem_we on the next cycle; throughput is one word per 2 cycles.
- Full:
  - in_ready stays 0 and further requests are ignored (not consumed) until clear or reset.
  - mem_addr holds at BASE_ADDR + 4*DEPTH.
- clear has priority over everything else:
  - A clear asserted during WRITE suppresses that cycle's mem_we. The word is dropped.
  - Next state is IDLE with reset values (except mem_wdata, which holds).
  - A request presented in the same cycle as clear is not accepted.
- Encodings (opcode / funct3 / funct7):
  - addi: 0010011 / 000, imm[11:0].
  - slli: 0010011 / 001, funct6=000000, shamt=imm[5:0].
  - add: 0110011 / 000 / 0000000.
  - sub: 0110011 / 000 / 0100000.
  - and: 0110011 / 111 / 0000000.
  - or: 0110011 / 110 / 0000000.
  - ld: 0000011 / 011, I format.
  - sd: 0100011 / 011, S format, imm split [11:5] | [4:0].
  - beq: 1100011 / 000, B format, bits {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11]}.
  - blt: 1100011 / 100, B format.
- Field usage: unused register fields are encoded from their inputs exactly as the format places them. in_rd is ignored for S/B types, and in_rs2 is ignored for I types.
- Encoding is purely from the registered request; no sign checking. Out-of-range immediates are truncated to the format width.
- Reset during WRITE: mem_we deasserts asynchronously. No partial increment of count or mem_addr.

Test Plan:
- Reset, then addi rd=5 rs1=0 imm=10 → one cycle after accept: mem_we=1, mem_addr=0x00, mem_wdata=0x00A00293; count becomes 1.
- Back-to-back stream (in_valid held high): add 3,1,2; sub 3,1,2; ld rd=6 rs1=2 imm=8; sd rs2=6 rs1=2 imm=16.
  - Required words: 0x002081B3, 0x402081B3, 0x00813303, 0x00613823.
  - Required addresses: 0x00, 0x04, 0x08, 0x0C.
  - in_ready must toggle 1/0 each cycle.
- Branches and shift:
  - beq rs1=1 rs2=2 imm=8 → 0x00208463.
  - blt rs1=1 rs2=2 imm=-4 (0x1FFC) → 0xFE20CEE3.
  - slli rd=7 rs1=7 imm=3 → 0x00339393.
- Illegal op 12 → err=1, no mem_we, count unchanged. A following legal request still writes normally; err remains 1.
- Fill to DEPTH=64:
  - After the 64th write: full=1, in_ready=0, mem_addr=0x100 (truncated to ADDR_W).
  - A 65th request stays pending.
  - After clear: full=0, count=0, mem_addr=0; the pending request is accepted on the following cycle.
- Simultaneous events:
  - Assert clear in a WRITE cycle → mem_we=0 that cycle, count=0 afterward.
  - Assert reset asynchronously mid-WRITE → mem_we falls immediately, all outputs at reset values.
